// File: rtl/logic_unit_arbiter.sv
// Purpose : round-robin arbiter sharing one registered logical unit among NUM_REQ issue ports.
// Latency : accept in cycle T, response valid from cycle T+3; at least 4 cycles per transaction.
// Backpr. : requests wait in IDLE until granted; RESP holds result until resp_ready of owner.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready   per-requester request handshake (ready is one-hot, IDLE only)
//   req_op/req_a/req_b    packed per-requester op (2b) and operands (WIDTH each)
//   resp_valid/resp_ready per-requester response handshake (valid is one-hot to owner)
//   resp_data             result of the current transaction
//   grant_id, busy        current owner index and in-flight indicator
//   lu_op/lu_a/lu_b       latched operation driven to the shared unit
//   lu_out                registered result returned by the shared unit
module logic_unit_arbiter #(
  parameter  int NUM_REQ = 4,
  parameter  int WIDTH   = 16,
  localparam int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [2*NUM_REQ-1:0]       req_op,
  input  logic [WIDTH*NUM_REQ-1:0]   req_a,
  input  logic [WIDTH*NUM_REQ-1:0]   req_b,
  output logic [NUM_REQ-1:0]         resp_valid,
  input  logic [NUM_REQ-1:0]         resp_ready,
  output logic [WIDTH-1:0]           resp_data,
  output logic [IDW-1:0]             grant_id,
  output logic                       busy,
  output logic [1:0]                 lu_op,
  output logic [WIDTH-1:0]           lu_a,
  output logic [WIDTH-1:0]           lu_b,
  input  logic [WIDTH-1:0]           lu_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t           state_q;
  logic [IDW-1:0]   rr_ptr_q;
  logic [IDW-1:0]   rr_ptr_d;
  logic [IDW-1:0]   grant_id_q;
  logic             busy_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] result_q;

  // Unpacked views of the packed request buses so the winner can index them.
  logic [1:0]       op_arr [NUM_REQ];
  logic [WIDTH-1:0] a_arr  [NUM_REQ];
  logic [WIDTH-1:0] b_arr  [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      op_arr[i] = req_op[2*i +: 2];
      a_arr[i]  = req_a[WIDTH*i +: WIDTH];
      b_arr[i]  = req_b[WIDTH*i +: WIDTH];
    end
  end

  // Round-robin search: first valid requester at or after rr_ptr, wrapping to 0.
  logic           found;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] cand_id;
  int             cand;

  always_comb begin
    found   = 1'b0;
    winner  = '0;
    cand    = 0;
    cand_id = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_id = IDW'(cand);
      if (!found && req_valid[cand_id]) begin
        found  = 1'b1;
        winner = cand_id;
      end
    end
  end

  assign rr_ptr_d = (winner == IDW'(NUM_REQ-1)) ? '0 : winner + 1'b1;

  // req_ready is gated by rst so nothing is offered while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (rst && state_q == S_IDLE && found) req_ready[winner] = 1'b1;
  end

  always_comb begin
    resp_valid = '0;
    if (state_q == S_RESP) resp_valid[grant_id_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (found) begin
            op_q       <= op_arr[winner];
            a_q        <= a_arr[winner];
            b_q        <= b_arr[winner];
            grant_id_q <= winner;
            rr_ptr_q   <= rr_ptr_d;
            busy_q     <= 1'b1;
            state_q    <= S_ISSUE;
          end
        end
        // Operands are already on lu_*; the unit captures them at this edge.
        S_ISSUE: state_q <= S_WAIT;
        S_WAIT: begin
          result_q <= lu_out;
          state_q  <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready[grant_id_q]) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign resp_data = result_q;
  assign grant_id  = grant_id_q;
  assign busy      = busy_q;
  assign lu_op     = op_q;
  assign lu_a      = a_q;
  assign lu_b      = b_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Purpose : directed self-checking bench for logic_unit_arbiter with a registered logic-unit model.
// Latency : n/a.
// Backpr. : n/a.
module tb_logic_unit_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 16;
  localparam int IDW     = 2;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [2*NUM_REQ-1:0]     req_op;
  logic [WIDTH*NUM_REQ-1:0] req_a;
  logic [WIDTH*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]       resp_valid;
  logic [NUM_REQ-1:0]       resp_ready;
  logic [WIDTH-1:0]         resp_data;
  logic [IDW-1:0]           grant_id;
  logic                     busy;
  logic [1:0]               lu_op;
  logic [WIDTH-1:0]         lu_a;
  logic [WIDTH-1:0]         lu_b;
  logic [WIDTH-1:0]         lu_out;

  logic_unit_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .grant_id   (grant_id),
    .busy       (busy),
    .lu_op      (lu_op),
    .lu_a       (lu_a),
    .lu_b       (lu_b),
    .lu_out     (lu_out)
  );

  always #5 clk = ~clk;

  // Shared logical unit: one registered stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lu_out <= '0;
    else begin
      case (lu_op)
        OP_AND:  lu_out <= lu_a & lu_b;
        OP_OR:   lu_out <= lu_a | lu_b;
        OP_XOR:  lu_out <= lu_a ^ lu_b;
        default: lu_out <= ~lu_a;
      endcase
    end
  end

  int cyc = 0;
  always_ff @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
  endtask

  task automatic set_req(input int idx, input logic [1:0] op,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_valid[idx]             = 1'b1;
    req_op[2*idx +: 2]         = op;
    req_a[WIDTH*idx +: WIDTH]  = a;
    req_b[WIDTH*idx +: WIDTH]  = b;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
    tick();
  endtask

  task automatic wait_grant(output int idx);
    int n;
    n   = 0;
    idx = -1;
    #1;
    while (req_ready == '0 && n < 20) begin
      tick();
      n++;
    end
    check("grant_seen", {31'b0, req_ready != '0}, 32'd1);
    for (int i = 0; i < NUM_REQ; i++)
      if (req_ready[i]) idx = i;
  endtask

  task automatic wait_resp();
    int n;
    n = 0;
    while (resp_valid == '0 && n < 20) begin
      tick();
      n++;
    end
    check("resp_seen", {31'b0, resp_valid != '0}, 32'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    check("idle_seen", {31'b0, busy}, 32'd0);
  endtask

  task automatic do_txn(input int idx, input logic [1:0] op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, output logic [WIDTH-1:0] res);
    int g;
    resp_ready = '1;
    set_req(idx, op, a, b);
    wait_grant(g);
    check("txn_grant", g, idx);
    tick();
    check("txn_grant_id", {30'b0, grant_id}, idx);
    req_valid[idx] = 1'b0;
    wait_resp();
    check("txn_resp_onehot", {28'b0, resp_valid}, 32'd1 << idx);
    res = resp_data;
    tick();
  endtask

  initial begin
    int g;
    int last;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] av;

    // Reset state, with requests present to show req_ready stays low.
    req_valid  = '1;
    req_op     = '0;
    req_a      = '1;
    req_b      = '0;
    resp_ready = '0;
    #3;
    check("rst_busy",       {31'b0, busy},       32'd0);
    check("rst_resp_valid", {28'b0, resp_valid}, 32'd0);
    check("rst_req_ready",  {28'b0, req_ready},  32'd0);
    check("rst_lu_a",       {16'b0, lu_a},       32'd0);
    check("rst_resp_data",  {16'b0, resp_data},  32'd0);
    clear_req();
    rst = 1'b1;
    tick();

    // 1: single AND with exact latency.
    resp_ready = '1;
    set_req(0, OP_AND, 16'h000B, 16'h000D);
    #1;
    check("t1_req_ready", {28'b0, req_ready}, 32'h1);
    tick();
    req_valid = '0;
    check("t1_busy",       {31'b0, busy},       32'd1);
    check("t1_grant",      {30'b0, grant_id},   32'd0);
    check("t1_lu_a",       {16'b0, lu_a},       32'h000B);
    check("t1_lu_b",       {16'b0, lu_b},       32'h000D);
    check("t1_ready_busy", {28'b0, req_ready},  32'd0);
    check("t1_rv_T1",      {28'b0, resp_valid}, 32'd0);
    tick();
    check("t1_rv_T2",      {28'b0, resp_valid}, 32'd0);
    tick();
    check("t1_rv_T3",      {28'b0, resp_valid}, 32'h1);
    check("t1_data",       {16'b0, resp_data},  32'h0009);
    tick();
    check("t1_idle_busy",  {31'b0, busy},       32'd0);
    check("t1_idle_rv",    {28'b0, resp_valid}, 32'd0);

    // 2: all requesters continuously valid -> 0,1,2,3,0, four cycles apart.
    clear_req();
    do_reset();
    resp_ready = '1;
    for (int i = 0; i < NUM_REQ; i++) begin
      av = 16'h1111 * WIDTH'(i + 1);
      set_req(i, OP_XOR, av, 16'h00FF);
    end
    last = 0;
    for (int n = 0; n < 5; n++) begin
      wait_grant(g);
      check("t2_rr_grant", g, n % NUM_REQ);
      if (n > 0) check("t2_rr_gap", cyc - last, 32'd4);
      last = cyc;
      tick();
      if (n == 4) req_valid = '0;
    end
    wait_resp();
    check("t2_last_data", {16'b0, resp_data}, 32'h11EE);
    wait_idle();

    // 3: OR / XOR / NOT on requester 1.
    clear_req();
    do_txn(1, OP_OR, 16'hF00F, 16'h0FF0, res);
    check("t3_or", {16'b0, res}, 32'hFFFF);
    clear_req();
    do_txn(1, OP_XOR, 16'hFFFF, 16'h00FF, res);
    check("t3_xor", {16'b0, res}, 32'hFF00);
    clear_req();
    do_txn(1, OP_NOT, 16'h1234, 16'hFFFF, res);
    check("t3_not", {16'b0, res}, 32'hEDCB);
    wait_idle();

    // 4: response backpressure; a waiting requester is not offered ready.
    clear_req();
    resp_ready = '0;
    set_req(0, OP_OR, 16'h00F0, 16'h000F);
    wait_grant(g);
    check("t4_grant0", g, 0);
    tick();
    req_valid = '0;
    set_req(2, OP_AND, 16'h0F0F, 16'h00FF);
    resp_ready = 4'b0100;
    tick();
    tick();
    for (int n = 0; n < 5; n++) begin
      check("t4_hold_rv",    {28'b0, resp_valid}, 32'h1);
      check("t4_hold_data",  {16'b0, resp_data},  32'h00FF);
      check("t4_hold_ready", {28'b0, req_ready},  32'd0);
      tick();
    end
    resp_ready = 4'b0001;
    tick();
    check("t4_req2_ready", {28'b0, req_ready}, 32'h4);
    tick();
    check("t4_grant2", {30'b0, grant_id}, 32'd2);
    req_valid  = '0;
    resp_ready = '1;
    wait_resp();
    check("t4_req2_data", {16'b0, resp_data}, 32'h000F);
    tick();
    wait_idle();

    // 5: grant to 3 wraps the pointer, search 0->1->2 finds 2, pointer then 3.
    clear_req();
    do_txn(3, OP_AND, 16'hFFFF, 16'h1234, res);
    check("t5_req3_data", {16'b0, res}, 32'h1234);
    clear_req();
    do_txn(2, OP_NOT, 16'h00FF, 16'h0000, res);
    check("t5_req2_data", {16'b0, res}, 32'hFF00);
    clear_req();
    set_req(0, OP_AND, 16'h0001, 16'h0001);
    set_req(3, OP_AND, 16'h0001, 16'h0001);
    wait_grant(g);
    check("t5_ptr3", g, 3);
    tick();
    clear_req();
    wait_idle();

    // 6: reset during ISSUE, then first grant searches from 0.
    clear_req();
    set_req(0, OP_AND, 16'h5555, 16'hFFFF);
    wait_grant(g);
    tick();
    check("t6_lu_a_issue", {16'b0, lu_a}, 32'h5555);
    rst = 1'b0;
    #1;
    check("t6_rst_busy", {31'b0, busy},       32'd0);
    check("t6_rst_rv",   {28'b0, resp_valid}, 32'd0);
    check("t6_rst_lu_a", {16'b0, lu_a},       32'd0);
    clear_req();
    set_req(1, OP_AND, 16'hFFFF, 16'hFFFF);
    set_req(0, OP_OR, 16'h0101, 16'h1010);
    rst = 1'b1;
    #1;
    check("t6_ready0", {28'b0, req_ready}, 32'h1);
    tick();
    check("t6_grant0", {30'b0, grant_id}, 32'd0);
    req_valid = '0;
    wait_resp();
    check("t6_data", {16'b0, resp_data}, 32'h1111);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
